ps2_host_tx: RTL and testbench

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_pkg.sv | 39 +++
 rtl/ps2_host_tx_if.sv | 49 ++++
 rtl/ps2_sync_edge.sv | 42 ++++
 rtl/ps2_host_tx.sv | 217 +++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 host transmitter and the PS/2 receiver.
//
// Contents:
//   ps2_tx_state_e    transmitter frame states
//   PS2_CMD_*         host-to-device command bytes
//   PS2_KEY_*         set-2 make codes the receiver side reacts to
//   ps2_odd_parity()  parity bit that makes a byte plus parity odd
// ---------------------------------------------------------------------------
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        REQ       = 3'd2,
        SEND      = 3'd3,
        ACK       = 3'd4,
        WAIT_IDLE = 3'd5
    } ps2_tx_state_e;

    // Host-to-device commands
    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;

    // Scan codes shared with the receiver (R, L, S)
    localparam logic [7:0] PS2_KEY_R = 8'h2D;
    localparam logic [7:0] PS2_KEY_L = 8'h4B;
    localparam logic [7:0] PS2_KEY_S = 8'h1B;

    // Falls counted while shifting: 8 data bits, parity, stop
    localparam logic [3:0] PS2_LAST_SEND_FALL = 4'd10;

    // Parity bit is 1 when the byte holds an even number of ones
    function automatic logic ps2_odd_parity(input logic [7:0] byte_i);
        return ~^byte_i;
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// ---------------------------------------------------------------------------
// ps2_host_tx_if
// Byte handshake and status bundle between a command source and the PS/2
// host transmitter.
//
// Signals:
//   tx_valid  source has a byte to send
//   tx_data   command byte
//   tx_ready  transmitter idle; byte accepted when tx_valid & tx_ready
//   busy      a frame is in progress (receiver should ignore the line)
//   done      one-cycle pulse at the end of every frame, good or bad
//   ack_err   with done: device did not acknowledge
//   timeout   with done: device stopped clocking
//
// Modports:
//   master  command source side
//   slave   transmitter side
// ---------------------------------------------------------------------------
interface ps2_host_tx_if;

    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic       timeout;

    modport master (
        output tx_valid,
        output tx_data,
        input  tx_ready,
        input  busy,
        input  done,
        input  ack_err,
        input  timeout
    );

    modport slave (
        input  tx_valid,
        input  tx_data,
        output tx_ready,
        output busy,
        output done,
        output ack_err,
        output timeout
    );

endinterface

// File: rtl/ps2_sync_edge.sv
// ---------------------------------------------------------------------------
// ps2_sync_edge
// Two-flop synchronizer for one raw PS/2 line plus falling-edge detect.
// Used for both the clock and data lines, by transmitter and receiver.
//
// Ports:
//   clk      system clock
//   rst      asynchronous active-high reset; all flops reset to 1 (idle line)
//   line_i   raw asynchronous line level
//   level_o  synchronized line level
//   fall_o   high for one cycle when the synchronized level goes 1 -> 0
// ---------------------------------------------------------------------------
module ps2_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic line_i,
    output logic level_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Resetting to 1 matches an idle pulled-up line, so no fall is seen
    // when reset is released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= line_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level_o = sync_q;
    assign fall_o  = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// ---------------------------------------------------------------------------
// ps2_host_tx
// PS/2 host-to-device byte transmitter. Inhibits the bus by holding the
// clock low, issues request-to-send (data low, clock released), then shifts
// the byte, odd parity and stop bit out on the device's falling clock edges,
// samples the device ACK bit and waits for the bus to go idle. A watchdog
// aborts the frame if the device stops clocking.
//
// Parameters:
//   INHIBIT_CYCLES  clk cycles the PS/2 clock is held low before the request
//   TIMEOUT_CYCLES  max clk cycles between device clock falls before abort
//
// Ports:
//   clk, rst              system clock, asynchronous active-high reset
//   host                  handshake/status bundle (ps2_host_tx_if.slave)
//   ps2_clk_in            raw PS/2 clock line level
//   ps2_data_in           raw PS/2 data line level
//   ps2_clk_oe            1 = pull PS/2 clock low, 0 = release
//   ps2_data_oe           1 = pull PS/2 data low, 0 = release
// ---------------------------------------------------------------------------
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic         clk,
    input  logic         rst,
    ps2_host_tx_if.slave host,
    input  logic         ps2_clk_in,
    input  logic         ps2_data_in,
    output logic         ps2_clk_oe,
    output logic         ps2_data_oe
);

    // Inhibit counter runs 0 .. INHIBIT_CYCLES-1; watchdog runs up to the limit
    localparam int unsigned INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

    ps2_tx_state_e    state_q,   state_d;
    logic [7:0]       data_q,    data_d;
    logic             parity_q,  parity_d;
    logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
    logic [TO_W-1:0]  to_cnt_q,  to_cnt_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic             nack_q,    nack_d;
    logic             clk_oe_q,  clk_oe_d;
    logic             data_oe_q, data_oe_d;

    logic clk_level;
    logic clk_fall;
    logic data_level;
    logic unused_data_fall;

    logic frame_active;
    logic done_c;
    logic ack_err_c;
    logic timeout_c;

    ps2_sync_edge u_clk_sync (
        .clk     (clk),
        .rst     (rst),
        .line_i  (ps2_clk_in),
        .level_o (clk_level),
        .fall_o  (clk_fall)
    );

    ps2_sync_edge u_data_sync (
        .clk     (clk),
        .rst     (rst),
        .line_i  (ps2_data_in),
        .level_o (data_level),
        .fall_o  (unused_data_fall)
    );

    // Watchdog only runs once the device owns the clock
    assign frame_active = (state_q == REQ)  || (state_q == SEND) ||
                          (state_q == ACK)  || (state_q == WAIT_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            data_q    <= '0;
            parity_q  <= 1'b0;
            inh_cnt_q <= '0;
            to_cnt_q  <= '0;
            bit_cnt_q <= '0;
            nack_q    <= 1'b0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            parity_q  <= parity_d;
            inh_cnt_q <= inh_cnt_d;
            to_cnt_q  <= to_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            nack_q    <= nack_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
        end
    end

    // Line drivers are registered and updated on the edge that ends the
    // synchronized-fall cycle, so every data change lands one cycle after
    // the fall while the device still holds its clock low.
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        parity_d  = parity_q;
        inh_cnt_d = inh_cnt_q;
        to_cnt_d  = to_cnt_q;
        bit_cnt_d = bit_cnt_q;
        nack_d    = nack_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        done_c    = 1'b0;
        ack_err_c = 1'b0;
        timeout_c = 1'b0;

        if (frame_active) begin
            to_cnt_d = clk_fall ? '0 : to_cnt_q + TO_W'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (host.tx_valid) begin
                    data_d    = host.tx_data;
                    parity_d  = ps2_odd_parity(host.tx_data);
                    nack_d    = 1'b0;
                    inh_cnt_d = '0;
                    clk_oe_d  = 1'b1;
                    data_oe_d = 1'b0;
                    state_d   = INHIBIT;
                end
            end

            // Falls seen here are contention from the device and are ignored
            INHIBIT: begin
                if (inh_cnt_q == INH_LAST) begin
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b1;
                    to_cnt_d  = '0;
                    state_d   = REQ;
                end else begin
                    inh_cnt_d = inh_cnt_q + INH_W'(1);
                end
            end

            REQ: begin
                bit_cnt_d = '0;
                state_d   = SEND;
            end

            // bit_cnt_q holds the number of falls already seen, so the
            // current fall is number bit_cnt_q+1.
            SEND: begin
                if (clk_fall) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q < 4'd8) begin
                        data_oe_d = ~data_q[bit_cnt_q[2:0]];
                    end else if (bit_cnt_q == 4'd8) begin
                        data_oe_d = ~parity_q;
                    end else begin
                        data_oe_d = 1'b0;
                        if (bit_cnt_d == PS2_LAST_SEND_FALL) begin
                            state_d = ACK;
                        end
                    end
                end
            end

            ACK: begin
                if (clk_fall) begin
                    nack_d  = data_level;
                    state_d = WAIT_IDLE;
                end
            end

            WAIT_IDLE: begin
                if (clk_level && data_level) begin
                    done_c    = 1'b1;
                    ack_err_c = nack_q;
                    state_d   = IDLE;
                end
            end

            default: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                state_d   = IDLE;
            end
        endcase

        // Watchdog abort overrides whatever the frame was doing
        if (frame_active && (to_cnt_q == TO_LIMIT)) begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            done_c    = 1'b1;
            ack_err_c = 1'b0;
            timeout_c = 1'b1;
            state_d   = IDLE;
        end
    end

    assign ps2_clk_oe    = clk_oe_q;
    assign ps2_data_oe   = data_oe_q;
    assign host.tx_ready = (state_q == IDLE);
    assign host.busy     = (state_q != IDLE);
    assign host.done     = done_c;
    assign host.ack_err  = ack_err_c;
    assign host.timeout  = timeout_c;

endmodule

// File: tb/tb_ps2_host_tx.sv
// ---------------------------------------------------------------------------
// tb_ps2_host_tx
// Directed-plus-random bench for ps2_host_tx. A behavioural PS/2 device
// clocks each frame out, samples the data line before each clock rise and
// optionally acknowledges. Expected frames are built from the byte with
// plain arithmetic (start 0, data LSB first, odd parity, stop 1).
// ---------------------------------------------------------------------------
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH  = 5000;
    localparam int TMO  = 3000;
    localparam int HALF = 20;

    logic clk        = 1'b0;
    logic rst        = 1'b1;
    logic devClkLow  = 1'b0;
    logic devDataLow = 1'b0;
    logic ps2ClkOe;
    logic ps2DataOe;
    logic ps2ClkIn;
    logic ps2DataIn;

    int checks = 0;
    int errors = 0;

    int   cyc            = 0;
    int   doneCount      = 0;
    int   doneCyc        = 0;
    logic doneAckErr     = 1'b0;
    logic doneTimeout    = 1'b0;
    logic readyAtDone    = 1'b0;
    logic readyAfterDone = 1'b0;
    logic doneLast       = 1'b0;
    logic prevDataOe     = 1'b0;
    int   viol           = 0;
    logic inFrame        = 1'b0;
    logic [10:0] frameBits = '0;
    int   lastRiseCyc    = 0;

    // Open-drain lines with pull-ups: either side can pull low
    assign ps2ClkIn  = ~(ps2ClkOe | devClkLow);
    assign ps2DataIn = ~(ps2DataOe | devDataLow);

    ps2_host_tx_if hostIf ();

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .host        (hostIf),
        .ps2_clk_in  (ps2ClkIn),
        .ps2_data_in (ps2DataIn),
        .ps2_clk_oe  (ps2ClkOe),
        .ps2_data_oe (ps2DataOe)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Status monitor, sampled on the falling system clock edge
    always @(negedge clk) begin
        if (doneLast) readyAfterDone = hostIf.tx_ready;
        doneLast = hostIf.done;
        if (hostIf.done) begin
            doneCount++;
            doneCyc     = cyc;
            doneAckErr  = hostIf.ack_err;
            doneTimeout = hostIf.timeout;
            readyAtDone = hostIf.tx_ready;
        end
        if (inFrame && ps2ClkIn && (ps2DataOe !== prevDataOe)) viol++;
        prevDataOe = ps2DataOe;
    end

    function automatic logic [10:0] refFrame(input logic [7:0] d);
        int ones;
        logic par;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        par = ((ones % 2) == 0) ? 1'b1 : 1'b0;
        return {1'b1, par, d, 1'b0};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] d, input bit hold);
        int b;
        b = 0;
        while (hostIf.tx_ready !== 1'b1 && b < 100) begin
            step();
            b++;
        end
        checkOutput("ready_before_send", 32'(hostIf.tx_ready), 32'd1);
        hostIf.tx_valid = 1'b1;
        hostIf.tx_data  = d;
        step();
        if (!hold) begin
            hostIf.tx_valid = 1'b0;
            hostIf.tx_data  = 8'($urandom);
        end
    endtask

    task automatic waitInhibit(output int reqCyc);
        int b;
        int n;
        logic dataSeen;
        b = 0;
        n = 0;
        dataSeen = 1'b0;
        while (ps2ClkOe !== 1'b1 && b < 100) begin
            step();
            b++;
        end
        lastRiseCyc = cyc;
        while (ps2ClkOe === 1'b1 && n < INH + 100) begin
            n++;
            if (ps2DataOe !== 1'b0) dataSeen = 1'b1;
            step();
        end
        checkOutput("inhibit_len", 32'(n), 32'(INH));
        checkOutput("inhibit_data_oe", 32'(dataSeen), 32'd0);
        checkOutput("req_data_oe", 32'(ps2DataOe), 32'd1);
        reqCyc = cyc;
    endtask

    task automatic deviceStart();
        repeat (50) step();
        frameBits[0] = ps2DataIn;
        inFrame = 1'b1;
    endtask

    task automatic deviceFalls(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            devClkLow = 1'b1;
            repeat (HALF) step();
            frameBits[i] = ps2DataIn;
            devClkLow = 1'b0;
            repeat (HALF) step();
        end
    endtask

    task automatic deviceAck(input bit ack);
        if (ack) devDataLow = 1'b1;
        repeat (5) step();
        devClkLow = 1'b1;
        repeat (HALF) step();
        devClkLow = 1'b0;
        repeat (5) step();
        devDataLow = 1'b0;
        inFrame = 1'b0;
    endtask

    task automatic waitDone(input int start);
        int b;
        b = 0;
        while (doneCount == start && b < 2 * TMO) begin
            step();
            b++;
        end
        checkOutput("done_seen", 32'(doneCount != start), 32'd1);
    endtask

    task automatic checkFrame(input logic [7:0] d, input bit ack, input int start);
        logic [10:0] expFrame;
        expFrame = refFrame(d);
        checkOutput("frame_bits", 32'(frameBits), 32'(expFrame));
        checkOutput("parity_bit", 32'(frameBits[9]), 32'(expFrame[9]));
        checkOutput("stop_bit", 32'(frameBits[10]), 32'd1);
        checkOutput("done_count", 32'(doneCount - start), 32'd1);
        checkOutput("ack_err", 32'(doneAckErr), 32'(!ack));
        checkOutput("timeout_flag", 32'(doneTimeout), 32'd0);
        checkOutput("ready_at_done", 32'(readyAtDone), 32'd0);
        checkOutput("hold_while_clk_high", 32'(viol), 32'd0);
        step();
        checkOutput("ready_after_done", 32'(readyAfterDone), 32'd1);
    endtask

    task automatic sendFrame(input logic [7:0] d, input bit ack);
        int start;
        int reqCyc;
        applyStimulus(d, 1'b0);
        waitInhibit(reqCyc);
        start = doneCount;
        deviceStart();
        deviceFalls(1, 10);
        deviceAck(ack);
        waitDone(start);
        checkFrame(d, ack, start);
        repeat (20) step();
        checkOutput("done_once", 32'(doneCount - start), 32'd1);
        checkOutput("idle_after", 32'(hostIf.tx_ready), 32'd1);
    endtask

    initial begin
        int start;
        int reqCyc;
        int firstDoneCyc;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] d;
        logic [10:0] expFrame;
        bit ack;

        hostIf.tx_valid = 1'b0;
        hostIf.tx_data  = 8'h00;

        // Reset state
        repeat (3) step();
        checkOutput("rst_clk_oe", 32'(ps2ClkOe), 32'd0);
        checkOutput("rst_data_oe", 32'(ps2DataOe), 32'd0);
        checkOutput("rst_tx_ready", 32'(hostIf.tx_ready), 32'd1);
        checkOutput("rst_busy", 32'(hostIf.busy), 32'd0);
        checkOutput("rst_done", 32'(hostIf.done), 32'd0);
        rst = 1'b0;
        repeat (3) step();

        $display("[TB] set-LEDs frame with ACK");
        sendFrame(PS2_CMD_SET_LEDS, 1'b1);

        $display("[TB] 0x01 frame with ACK");
        sendFrame(8'h01, 1'b1);

        $display("[TB] NACK frame");
        sendFrame(PS2_KEY_L, 1'b0);

        $display("[TB] device never clocks");
        applyStimulus(PS2_KEY_R, 1'b0);
        waitInhibit(reqCyc);
        start = doneCount;
        waitDone(start);
        checkOutput("to_timeout_flag", 32'(doneTimeout), 32'd1);
        checkOutput("to_ack_err", 32'(doneAckErr), 32'd0);
        checkOutput("to_latency", 32'(doneCyc - reqCyc), 32'(TMO));
        step();
        checkOutput("to_clk_oe", 32'(ps2ClkOe), 32'd0);
        checkOutput("to_data_oe", 32'(ps2DataOe), 32'd0);
        checkOutput("to_ready", 32'(hostIf.tx_ready), 32'd1);

        $display("[TB] reset after 4th fall");
        d = 8'($urandom);
        d[3] = 1'b0;
        applyStimulus(d, 1'b0);
        waitInhibit(reqCyc);
        start = doneCount;
        deviceStart();
        deviceFalls(1, 3);
        devClkLow = 1'b1;
        repeat (10) step();
        checkOutput("pre_rst_data_oe", 32'(ps2DataOe), 32'd1);
        inFrame = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_clk_oe", 32'(ps2ClkOe), 32'd0);
        checkOutput("rst_mid_data_oe", 32'(ps2DataOe), 32'd0);
        checkOutput("rst_mid_ready", 32'(hostIf.tx_ready), 32'd1);
        devClkLow = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        repeat (20) step();
        checkOutput("rst_mid_no_done", 32'(doneCount - start), 32'd0);
        sendFrame(PS2_CMD_RESET, 1'b1);

        $display("[TB] tx_valid held through a frame");
        a = 8'($urandom);
        b = 8'($urandom);
        applyStimulus(a, 1'b1);
        hostIf.tx_data = b;
        waitInhibit(reqCyc);
        start = doneCount;
        deviceStart();
        deviceFalls(1, 10);
        deviceAck(1'b1);
        waitDone(start);
        firstDoneCyc = doneCyc;
        checkFrame(a, 1'b1, start);
        waitInhibit(reqCyc);
        checkOutput("held_restart_cyc", 32'(lastRiseCyc), 32'(firstDoneCyc + 2));
        hostIf.tx_valid = 1'b0;
        start = doneCount;
        deviceStart();
        deviceFalls(1, 10);
        deviceAck(1'b1);
        waitDone(start);
        expFrame = refFrame(b);
        checkOutput("held_second_bits", 32'(frameBits), 32'(expFrame));
        repeat (30) step();
        checkOutput("held_no_third", 32'(ps2ClkOe), 32'd0);
        checkOutput("held_done_once", 32'(doneCount - start), 32'd1);

        $display("[TB] random frames");
        for (int k = 0; k < 2; k++) begin
            d   = 8'($urandom);
            ack = 1'($urandom_range(0, 1));
            sendFrame(d, ack);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
